// File: rtl/dbus_arbiter_pkg.sv
// Shared constants and types for the two-master data-bus arbiter.
// Optional feature macro used by this slice: DBUS_ARB_RR_EN (round-robin tie-break).
package dbus_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] AMO_LR = 5'b00010;
  localparam logic [4:0] AMO_SC = 5'b00011;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dbus_arb_pick.sv
// Combinational 2-way winner selection with LR/SC lock filtering.
// DBUS_ARB_RR_EN defined: ties go to !last_grant; undefined: m0 wins ties.
module dbus_arb_pick
  import dbus_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_lock_valid,
  input  logic       i_lock_owner,
  output logic       o_grant,
  output logic       o_valid
);

  logic [1:0] w_elig;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_elig = i_req;
    if (i_lock_valid) begin
      w_elig = i_req & (i_lock_owner ? 2'b10 : 2'b01);
    end
  end

  assign o_valid = |w_elig;

  always_comb begin
    o_grant = w_elig[1] & ~w_elig[0];
    if (&w_elig) begin
`ifdef DBUS_ARB_RR_EN
      o_grant = ~i_last_grant;
`else
      o_grant = 1'b0;
`endif
    end
  end

`ifndef DBUS_ARB_RR_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter with a registered grant FSM and an LR/SC reservation lock.
// Tie-break policy selected by DBUS_ARB_RR_EN (see dbus_arb_pick).
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int LOCK_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_re,
  input  logic              m0_we,
  input  logic              m0_atomic,
  input  logic [4:0]        m0_amo_op,
  input  logic [XLEN/8-1:0] m0_sel,
  input  logic [XLEN-1:0]   m0_addr,
  input  logic [XLEN-1:0]   m0_data_w,
  output logic              m0_ack,
  output logic [XLEN-1:0]   m0_data_r,

  input  logic              m1_re,
  input  logic              m1_we,
  input  logic              m1_atomic,
  input  logic [4:0]        m1_amo_op,
  input  logic [XLEN/8-1:0] m1_sel,
  input  logic [XLEN-1:0]   m1_addr,
  input  logic [XLEN-1:0]   m1_data_w,
  output logic              m1_ack,
  output logic [XLEN-1:0]   m1_data_r,

  output logic              s_re,
  output logic              s_we,
  output logic              s_atomic,
  output logic [4:0]        s_amo_op,
  output logic [XLEN/8-1:0] s_sel,
  output logic [XLEN-1:0]   s_addr,
  output logic [XLEN-1:0]   s_data_w,
  input  logic              s_ack,
  input  logic [XLEN-1:0]   s_data_r
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LOCK_CYCLES > 0) ? LOCK_CYCLES - 1 : 0);

  arb_state_e       r_state;
  logic             r_owner;
  logic             r_last_grant;
  logic             r_lock_valid;
  logic             r_lock_owner;
  logic [CNT_W-1:0] r_lock_cnt;

  logic       w_grant;
  logic       w_grant_valid;
  logic       w_xfer;
  logic       w_xfer_ack;
  logic       w_own_atomic;
  logic [4:0] w_own_op;
  logic       w_lr_ack;
  logic       w_sc_ack;

  dbus_arb_pick u_pick (
    .i_req        ({m1_re | m1_we, m0_re | m0_we}),
    .i_last_grant (r_last_grant),
    .i_lock_valid (r_lock_valid),
    .i_lock_owner (r_lock_owner),
    .o_grant      (w_grant),
    .o_valid      (w_grant_valid)
  );

  assign w_xfer     = (r_state == ARB_XFER);
  assign w_xfer_ack = w_xfer & s_ack;

  assign w_own_atomic = r_owner ? m1_atomic : m0_atomic;
  assign w_own_op     = r_owner ? m1_amo_op : m0_amo_op;

  // Strobes are gated by XFER so the bus is quiet in IDLE; payload fields just follow the owner.
  assign s_re     = w_xfer & (r_owner ? m1_re : m0_re);
  assign s_we     = w_xfer & (r_owner ? m1_we : m0_we);
  assign s_atomic = w_xfer & w_own_atomic;
  assign s_amo_op = w_own_op;
  assign s_sel    = r_owner ? m1_sel    : m0_sel;
  assign s_addr   = r_owner ? m1_addr   : m0_addr;
  assign s_data_w = r_owner ? m1_data_w : m0_data_w;

  assign m0_ack    = w_xfer_ack & ~r_owner;
  assign m1_ack    = w_xfer_ack &  r_owner;
  assign m0_data_r = s_data_r;
  assign m1_data_r = s_data_r;

  assign w_lr_ack = (LOCK_CYCLES != 0) && w_xfer_ack && w_own_atomic && (w_own_op == AMO_LR);
  assign w_sc_ack = w_xfer_ack && r_lock_valid && (r_owner == r_lock_owner) &&
                    w_own_atomic && (w_own_op == AMO_SC);

  // NOTE: sequential state is written only with non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (s_ack) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Reload beats expiry; SC completion beats expiry (both clear or keep consistently).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
      r_lock_cnt   <= '0;
    end else if (w_lr_ack) begin
      r_lock_valid <= 1'b1;
      r_lock_owner <= r_owner;
      r_lock_cnt   <= CNT_LOAD;
    end else if (w_sc_ack) begin
      r_lock_valid <= 1'b0;
    end else if (r_lock_valid) begin
      if (r_lock_cnt == '0) begin
        r_lock_valid <= 1'b0;
      end else begin
        r_lock_cnt <= r_lock_cnt - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_m0_hold: assert property (@(posedge clk) disable iff (rst)
    ((m0_re | m0_we) && !m0_ack) |=> (m0_re | m0_we));
  a_m1_hold: assert property (@(posedge clk) disable iff (rst)
    ((m1_re | m1_we) && !m1_ack) |=> (m1_re | m1_we));
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: three instances (LOCK_CYCLES 64, 4, 0) driven by hand-timed vectors.
// Tie expectations follow DBUS_ARB_RR_EN when it is defined for the build.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]      m0_re, m0_we, m0_atomic, m0_ack;
  logic [N-1:0]      m1_re, m1_we, m1_atomic, m1_ack;
  logic [4:0]        m0_amo_op [N];
  logic [4:0]        m1_amo_op [N];
  logic [XLEN/8-1:0] m0_sel [N];
  logic [XLEN/8-1:0] m1_sel [N];
  logic [XLEN-1:0]   m0_addr [N];
  logic [XLEN-1:0]   m1_addr [N];
  logic [XLEN-1:0]   m0_data_w [N];
  logic [XLEN-1:0]   m1_data_w [N];
  logic [XLEN-1:0]   m0_data_r [N];
  logic [XLEN-1:0]   m1_data_r [N];
  logic [N-1:0]      s_re, s_we, s_atomic, s_ack;
  logic [4:0]        s_amo_op [N];
  logic [XLEN/8-1:0] s_sel [N];
  logic [XLEN-1:0]   s_addr [N];
  logic [XLEN-1:0]   s_data_w [N];
  logic [XLEN-1:0]   s_data_r [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dbus_arbiter #(.LOCK_CYCLES(g == 0 ? 64 : (g == 1 ? 4 : 0))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_re     (m0_re[g]),
      .m0_we     (m0_we[g]),
      .m0_atomic (m0_atomic[g]),
      .m0_amo_op (m0_amo_op[g]),
      .m0_sel    (m0_sel[g]),
      .m0_addr   (m0_addr[g]),
      .m0_data_w (m0_data_w[g]),
      .m0_ack    (m0_ack[g]),
      .m0_data_r (m0_data_r[g]),
      .m1_re     (m1_re[g]),
      .m1_we     (m1_we[g]),
      .m1_atomic (m1_atomic[g]),
      .m1_amo_op (m1_amo_op[g]),
      .m1_sel    (m1_sel[g]),
      .m1_addr   (m1_addr[g]),
      .m1_data_w (m1_data_w[g]),
      .m1_ack    (m1_ack[g]),
      .m1_data_r (m1_data_r[g]),
      .s_re      (s_re[g]),
      .s_we      (s_we[g]),
      .s_atomic  (s_atomic[g]),
      .s_amo_op  (s_amo_op[g]),
      .s_sel     (s_sel[g]),
      .s_addr    (s_addr[g]),
      .s_data_w  (s_data_w[g]),
      .s_ack     (s_ack[g]),
      .s_data_r  (s_data_r[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int m, input logic we, input logic atomic,
                         input logic [4:0] op, input logic [XLEN-1:0] addr);
    if (m == 0) begin
      m0_re[k] = ~we; m0_we[k] = we; m0_atomic[k] = atomic; m0_amo_op[k] = op;
      m0_sel[k] = '1; m0_addr[k] = addr; m0_data_w[k] = ~addr;
    end else begin
      m1_re[k] = ~we; m1_we[k] = we; m1_atomic[k] = atomic; m1_amo_op[k] = op;
      m1_sel[k] = '1; m1_addr[k] = addr; m1_data_w[k] = ~addr;
    end
  endtask

  task automatic drop_req(input int k, input int m);
    if (m == 0) begin
      m0_re[k] = 1'b0; m0_we[k] = 1'b0; m0_atomic[k] = 1'b0;
    end else begin
      m1_re[k] = 1'b0; m1_we[k] = 1'b0; m1_atomic[k] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_mode;
    int w;
    int rest;
`ifdef DBUS_ARB_RR_EN
    rr_mode = 1;
`else
    rr_mode = 0;
`endif
    m0_re = '0; m0_we = '0; m0_atomic = '0;
    m1_re = '0; m1_we = '0; m1_atomic = '0;
    s_ack = '0;
    for (int k = 0; k < N; k++) begin
      m0_amo_op[k] = '0; m1_amo_op[k] = '0; m0_sel[k] = '0; m1_sel[k] = '0;
      m0_addr[k] = '0; m1_addr[k] = '0; m0_data_w[k] = '0; m1_data_w[k] = '0;
      s_data_r[k] = '0;
    end

    // Reset state on every instance
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_s_re%0d", k), 32'(s_re[k]), 0);
      check($sformatf("rst_s_we%0d", k), 32'(s_we[k]), 0);
      check($sformatf("rst_s_atomic%0d", k), 32'(s_atomic[k]), 0);
      check($sformatf("rst_acks%0d", k), 32'({m1_ack[k], m0_ack[k]}), 0);
    end

    // 1: lone m0 read, downstream acks 3 cycles after s_re rises
    set_req(0, 0, 1'b0, 1'b0, 5'd0, 32'h100);
    #1 check("t1_idle_quiet", 32'(s_re[0]), 0);
    cyc();
    check("t1_s_re", 32'(s_re[0]), 1);
    check("t1_s_addr", s_addr[0], 32'h100);
    check("t1_no_early_ack", 32'(m0_ack[0]), 0);
    cyc();
    check("t1_wait1", 32'(m0_ack[0]), 0);
    cyc();
    check("t1_wait2", 32'(m0_ack[0]), 0);
    cyc();
    s_ack[0] = 1'b1; s_data_r[0] = 32'hDEAD_BEEF;
    #1;
    check("t1_m0_ack", 32'(m0_ack[0]), 1);
    check("t1_m0_data", m0_data_r[0], 32'hDEAD_BEEF);
    check("t1_m1_ack", 32'(m1_ack[0]), 0);
    cyc();
    s_ack[0] = 1'b0; drop_req(0, 0);
    #1;
    check("t1_single_ack", 32'(m0_ack[0]), 0);
    check("t1_back_idle", 32'(s_re[0]), 0);

    // 2: four ties on a freshly reset instance; both masters keep requesting
    cyc();
    set_req(1, 0, 1'b0, 1'b0, 5'd0, 32'h200);
    set_req(1, 1, 1'b1, 1'b0, 5'd0, 32'h300);
    w = 0;
    for (int i = 0; i < 4; i++) begin
      w = (rr_mode != 0) ? (i % 2) : 0;
      cyc();
      s_ack[1] = 1'b1; s_data_r[1] = 32'h1000 + 32'(i);
      #1;
      check($sformatf("t2_tie%0d_addr", i), s_addr[1], (w != 0) ? 32'h300 : 32'h200);
      check($sformatf("t2_tie%0d_acks", i), 32'({m1_ack[1], m0_ack[1]}), (w != 0) ? 32'd2 : 32'd1);
      cyc();
      s_ack[1] = 1'b0;
    end
    rest = 1 - w;
    drop_req(1, w);
    cyc();
    s_ack[1] = 1'b1;
    #1;
    check("t2_rest_addr", s_addr[1], (rest != 0) ? 32'h300 : 32'h200);
    cyc();
    s_ack[1] = 1'b0; drop_req(1, rest);

    // 3: m0 LR, m1 write waits through the lock until m0's SC completes
    cyc();
    set_req(0, 0, 1'b0, 1'b1, AMO_LR, 32'h400);
    cyc();
    set_req(0, 1, 1'b1, 1'b0, 5'd0, 32'h500);
    s_ack[0] = 1'b1; s_data_r[0] = 32'h11;
    #1;
    check("t3_lr_atomic", 32'(s_atomic[0]), 1);
    check("t3_lr_ack", 32'(m0_ack[0]), 1);
    cyc();
    s_ack[0] = 1'b0; drop_req(0, 0);
    #1 check("t3_locked0", 32'(s_we[0]), 0);
    for (int i = 1; i < 3; i++) begin
      cyc();
      check($sformatf("t3_locked%0d", i), 32'({s_we[0], m1_ack[0]}), 0);
    end
    set_req(0, 0, 1'b1, 1'b1, AMO_SC, 32'h400);
    cyc();
    s_ack[0] = 1'b1;
    #1;
    check("t3_sc_addr", s_addr[0], 32'h400);
    check("t3_sc_acks", 32'({m1_ack[0], m0_ack[0]}), 1);
    cyc();
    s_ack[0] = 1'b0; drop_req(0, 0);
    #1 check("t3_gap_idle", 32'(s_we[0]), 0);
    cyc();
    s_ack[0] = 1'b1;
    #1;
    check("t3_m1_addr", s_addr[0], 32'h500);
    check("t3_m1_ack", 32'(m1_ack[0]), 1);
    cyc();
    s_ack[0] = 1'b0; drop_req(0, 1);

    // 5: reset one cycle into XFER, then a stray s_ack while IDLE
    cyc();
    set_req(0, 0, 1'b1, 1'b0, 5'd0, 32'h600);
    cyc();
    check("t5_s_we_before", 32'(s_we[0]), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; drop_req(0, 0);
    #1;
    check("t5_s_req_dropped", 32'({s_re[0], s_we[0]}), 0);
    check("t5_no_ack_rst", 32'(m0_ack[0]), 0);
    cyc();
    s_ack[0] = 1'b1;
    #1;
    check("t5_late_ack_ignored", 32'({m1_ack[0], m0_ack[0]}), 0);
    check("t5_still_idle", 32'(s_we[0]), 0);
    cyc();
    s_ack[0] = 1'b0;

    // 4: LOCK_CYCLES=4, LR never followed by SC; lock covers 4 cycles after the LR ack
    cyc();
    set_req(1, 0, 1'b0, 1'b1, AMO_LR, 32'h700);
    cyc();
    set_req(1, 1, 1'b1, 1'b0, 5'd0, 32'h800);
    s_ack[1] = 1'b1;
    #1 check("t4_lr_ack", 32'(m0_ack[1]), 1);
    cyc();
    s_ack[1] = 1'b0; drop_req(1, 0);
    #1 check("t4_held1", 32'(s_we[1]), 0);
    for (int i = 2; i <= 5; i++) begin
      cyc();
      check($sformatf("t4_held%0d", i), 32'(s_we[1]), 0);
    end
    cyc();
    s_ack[1] = 1'b1;
    #1;
    check("t4_m1_granted", 32'(s_we[1]), 1);
    check("t4_m1_addr", s_addr[1], 32'h800);
    check("t4_m1_ack", 32'(m1_ack[1]), 1);
    cyc();
    s_ack[1] = 1'b0; drop_req(1, 1);

    // 6: LOCK_CYCLES=0, an LR takes no lock
    cyc();
    set_req(2, 0, 1'b0, 1'b1, AMO_LR, 32'h900);
    cyc();
    set_req(2, 1, 1'b1, 1'b0, 5'd0, 32'hA00);
    s_ack[2] = 1'b1;
    #1 check("t6_lr_ack", 32'(m0_ack[2]), 1);
    cyc();
    s_ack[2] = 1'b0; drop_req(2, 0);
    #1 check("t6_idle", 32'(s_we[2]), 0);
    cyc();
    s_ack[2] = 1'b1;
    #1;
    check("t6_m1_addr", s_addr[2], 32'hA00);
    check("t6_m1_ack", 32'(m1_ack[2]), 1);
    cyc();
    s_ack[2] = 1'b0; drop_req(2, 1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
